dmsc_window_ctrl: RTL

Frame sequencer for the demosaic 3x3 window datapath. It accepts a raw Bayer pixel stream under valid/ready and drives the advance strobe for the line buffers and horizontal shift registers. It tracks input and window-center coordinates, inserts padding advances at frame end to flush the last row, and emits a registered per-window sideband: center x/y, Bayer pixel type and border flags. It sits between the sensor input stage and the interpolation datapath, and is the only block that decides when the window pipeline moves.

---
 rtl/dmsc_pkg.sv | 40 ++++
 rtl/dmsc_xy_wrap.sv | 60 ++++++
 rtl/dmsc_window_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmsc_pkg
// Purpose  : Shared types and constants for the demosaic window controller:
//            Bayer pixel-type codes, FSM state encoding, border-flag bit
//            positions and a pixel-type helper for an RGGB mosaic.
// Revision : 1.0 - initial release
// ============================================================================
package dmsc_pkg;

    localparam logic [1:0] PT_R = 2'b00;
    localparam logic [1:0] PT_G = 2'b01;
    localparam logic [1:0] PT_B = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } dmsc_state_t;

    // Bit positions inside the {top, bottom, left, right} border vector
    localparam int BRD_TOP   = 3;
    localparam int BRD_BOT   = 2;
    localparam int BRD_LEFT  = 1;
    localparam int BRD_RIGHT = 0;

    // RGGB: even row/even col is R, odd/odd is B, the two mixed sites are G
    function automatic logic [1:0] pix_type(input logic y0, input logic x0);
        logic [1:0] t;
        case ({y0, x0})
            2'b00:   t = PT_R;
            2'b11:   t = PT_B;
            default: t = PT_G;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmsc_xy_wrap.sv
`default_nettype none
// ============================================================================
// Module   : dmsc_xy_wrap
// Purpose  : Raster x/y counter. x wraps at IMG_W-1 and carries into y,
//            y wraps at IMG_H-1.
// Ports    : clk, rst (async, active high)
//            clr_i  - return to (0,0); combined with en_i the result is the
//                     step after (0,0)
//            en_i   - advance one position
//            x_o/y_o- current position
// Revision : 1.0 - initial release
// ============================================================================
module dmsc_xy_wrap #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12,
    parameter int IMG_W   = 1920,
    parameter int IMG_H   = 1080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [X_WIDTH-1:0] x_o,
    output logic [Y_WIDTH-1:0] y_o
);

    localparam logic [X_WIDTH-1:0] C_X_LAST = X_WIDTH'(IMG_W - 1);
    localparam logic [Y_WIDTH-1:0] C_Y_LAST = Y_WIDTH'(IMG_H - 1);

    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;

    always_comb begin
        x_d = clr_i ? '0 : x_q;
        y_d = clr_i ? '0 : y_q;
        if (en_i) begin
            if (x_d == C_X_LAST) begin
                x_d = '0;
                y_d = (y_d == C_Y_LAST) ? '0 : y_d + 1'b1;
            end else begin
                x_d = x_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/dmsc_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmsc_window_ctrl
// Purpose  : Frame sequencer for the demosaic 3x3 window pipeline. Accepts
//            a Bayer stream, drives the advance strobe (adv/pad/lb_addr) and
//            emits a registered window sideband (center x/y, type, border).
// Ports    : s_valid/s_ready/s_sof/s_eol - pixel input handshake
//            adv/pad/lb_addr             - combinational advance strobe
//            win_valid/win_ready/win_*   - registered window sideband
//            busy, err_sync              - status
// Config   : DMSC_BORDER_REPLICATE_EN - when defined every center is emitted
//            with border flags; otherwise only interior centers are emitted
//            and win_border is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmsc_window_ctrl
    import dmsc_pkg::*;
#(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12,
    parameter int IMG_W   = 1920,
    parameter int IMG_H   = 1080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_sof,
    input  logic               s_eol,
    output logic               adv,
    output logic               pad,
    output logic [X_WIDTH-1:0] lb_addr,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [X_WIDTH-1:0] win_x,
    output logic [Y_WIDTH-1:0] win_y,
    output logic [1:0]         win_type,
    output logic [3:0]         win_border,
    output logic               busy,
    output logic               err_sync
);

    localparam logic [X_WIDTH-1:0] C_X_LAST = X_WIDTH'(IMG_W - 1);
    localparam logic [Y_WIDTH-1:0] C_Y_LAST = Y_WIDTH'(IMG_H - 1);

    dmsc_state_t        state_q, state_d;
    logic               win_valid_q, win_valid_d;
    logic [X_WIDTH-1:0] win_x_q, win_x_d;
    logic [Y_WIDTH-1:0] win_y_q, win_y_d;
    logic [1:0]         win_type_q, win_type_d;
    logic [3:0]         win_border_q, win_border_d;
    logic               err_q, err_d;

    logic [X_WIDTH-1:0] in_x, c_x;
    logic [Y_WIDTH-1:0] in_y, c_y;

    logic step_ok, acc, sof_acc, pix_adv, win_gen, win_emit, eol_bad;
    logic [3:0] border_now;

    // Input coordinates step on every advance, including padding, so that
    // lb_addr keeps wrapping through the flush.
    dmsc_xy_wrap #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H))
    u_in_xy (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sof_acc),
        .en_i  (adv),
        .x_o   (in_x),
        .y_o   (in_y)
    );

    dmsc_xy_wrap #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H))
    u_c_xy (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sof_acc),
        .en_i  (win_gen),
        .x_o   (c_x),
        .y_o   (c_y)
    );

    always_comb begin
        step_ok = !win_valid_q || win_ready;
        s_ready = !rst && (state_q != FLUSH) && step_ok;
        acc     = s_valid && s_ready;
        sof_acc = acc && s_sof;
        // In IDLE only a start-of-frame pixel enters the pipe; others are dropped
        pix_adv = acc && ((state_q != IDLE) || s_sof);
        pad     = (state_q == FLUSH) && step_ok;
        adv     = pix_adv || pad;
        // A start-of-frame pixel is always column 0, even when it aborts a frame
        lb_addr = sof_acc ? '0 : in_x;
        eol_bad = pix_adv && (s_eol != (lb_addr == C_X_LAST));
        win_gen = adv && !sof_acc && ((state_q == RUN) || (state_q == FLUSH));

        border_now             = '0;
        border_now[BRD_TOP]    = (c_y == '0);
        border_now[BRD_BOT]    = (c_y == C_Y_LAST);
        border_now[BRD_LEFT]   = (c_x == '0);
        border_now[BRD_RIGHT]  = (c_x == C_X_LAST);
`ifdef DMSC_BORDER_REPLICATE_EN
        win_emit = win_gen;
`else
        win_emit = win_gen && (border_now == 4'b0000);
`endif
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sof_acc) state_d = PRIME;
            PRIME: begin
                if (sof_acc)
                    state_d = PRIME;
                // Advance IMG_W (0-based) is pixel (0,1): last priming step
                else if (pix_adv && (in_x == '0) && (in_y == Y_WIDTH'(1)))
                    state_d = RUN;
            end
            RUN: begin
                if (sof_acc)
                    state_d = PRIME;
                else if (pix_adv && (in_x == C_X_LAST) && (in_y == C_Y_LAST))
                    state_d = FLUSH;
            end
            FLUSH:   if (pad && (c_x == C_X_LAST) && (c_y == C_Y_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sticky framing error and window sideband
    always_comb begin
        err_d = err_q;
        if (sof_acc && (state_q == IDLE)) err_d = 1'b0;
        if (sof_acc && (state_q != IDLE)) err_d = 1'b1;
        if (eol_bad)                      err_d = 1'b1;

        win_valid_d  = win_valid_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;
        win_type_d   = win_type_q;
        win_border_d = win_border_q;
        // An advance only happens when the register is free or being drained,
        // so it always overwrites; otherwise a consumed window just clears.
        if (adv)
            win_valid_d = win_emit;
        else if (win_ready)
            win_valid_d = 1'b0;
        if (win_emit) begin
            win_x_d    = c_x;
            win_y_d    = c_y;
            win_type_d = pix_type(c_y[0], c_x[0]);
`ifdef DMSC_BORDER_REPLICATE_EN
            win_border_d = border_now;
`else
            win_border_d = 4'b0000;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            win_type_q   <= '0;
            win_border_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            win_type_q   <= win_type_d;
            win_border_q <= win_border_d;
            err_q        <= err_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign win_type   = win_type_q;
    assign win_border = win_border_q;
    assign busy       = (state_q != IDLE);
    assign err_sync   = err_q;

endmodule
`default_nettype wire
